// File: rtl/accumulator_bank.sv
// accumulator_bank: NUM_CH frame accumulators feeding one valid/ready result register.
// Define ACC_SATURATE_EN to clamp channel sums on overflow instead of wrapping.
module accumulator_bank #(
    parameter int NUM_CH    = 4,
    parameter int IN_WIDTH  = 15,
    parameter int ACC_WIDTH = 21,
    parameter int CNT_WIDTH = 8,
    parameter int IS_SIGNED = 1,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH_W-1:0]      in_ch,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH_W-1:0]      out_ch,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_ovf
);

    localparam int M = ACC_WIDTH - 1;

    logic [ACC_WIDTH-1:0] sum_q [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
    logic [NUM_CH-1:0]    ovf_q;

    logic                 ch_ok;
    logic                 accept;
    logic                 load;
    logic [ACC_WIDTH-1:0] cur;
    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH-1:0] raw;
    logic [ACC_WIDTH-1:0] nxt_sum;
    logic                 carry;
    logic                 add_ovf;
    logic [CNT_WIDTH-1:0] cur_cnt;
    logic [CNT_WIDTH-1:0] nxt_cnt;
    logic                 cur_ovf;

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign load     = accept && ch_ok && in_last;

    // Single read-modify-write path: the selected channel is read, summed
    // and written back in one cycle, so back-to-back samples need no bypass.
    always_comb begin
        ch_ok   = 32'(in_ch) < 32'(NUM_CH);
        cur     = '0;
        cur_cnt = '0;
        cur_ovf = 1'b0;
        if (ch_ok) begin
            cur     = sum_q[in_ch];
            cur_cnt = cnt_q[in_ch];
            cur_ovf = ovf_q[in_ch];
        end
        ext = ACC_WIDTH'(in_data);
        if (IS_SIGNED != 0 && in_data[IN_WIDTH-1])
            ext = ext | ~ACC_WIDTH'({IN_WIDTH{1'b1}});
        {carry, raw} = {1'b0, cur} + {1'b0, ext};
        if (IS_SIGNED != 0)
            add_ovf = (cur[M] == ext[M]) && (raw[M] != cur[M]);
        else
            add_ovf = carry;
        nxt_sum = raw;
`ifdef ACC_SATURATE_EN
        if (add_ovf) begin
            if (IS_SIGNED != 0)
                nxt_sum = cur[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
            else
                nxt_sum = '1;
        end
`endif
        nxt_cnt = (&cur_cnt) ? cur_cnt : cur_cnt + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sum_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else if (accept && ch_ok) begin
            if (in_last) begin
                sum_q[in_ch] <= '0;
                cnt_q[in_ch] <= '0;
                ovf_q[in_ch] <= 1'b0;
            end else begin
                sum_q[in_ch] <= nxt_sum;
                cnt_q[in_ch] <= nxt_cnt;
                ovf_q[in_ch] <= cur_ovf | add_ovf;
            end
        end
    end

    // Flush leaves a pending result alone so its handshake can finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_ch    <= in_ch;
            out_data  <= nxt_sum;
            out_count <= nxt_cnt;
            out_ovf   <= cur_ovf | add_ovf;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
